voq_rx_arbiter: RTL and testbench

Round-robin ingress arbiter that sits directly upstream of the VOQ input stage. Collects frames from `PORT_NUB` receive ports and streams one whole frame at a time onto the single VOQ ingress bus as `{dest, word}`, tagged with the source port number. Honours the VOQ one-cycle-delayed backpressure. Polices frame length and destination, and drops bad traffic.

---
 rtl/voq_rx_arbiter.sv | 147 ++++++++++++++
 tb/tb_voq_rx_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/voq_rx_arbiter.sv
// rtl/voq_rx_arbiter.sv - round-robin frame arbiter feeding the VOQ ingress bus
// Grants one receive port per frame, polices length/destination, honours delayed VOQ full.
module voq_rx_arbiter #(
  parameter int PORT_NUB   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH_SEL  = $clog2(PORT_NUB),
  parameter int LENGTH_MAX = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [PORT_NUB-1:0]             rx_valid,
  input  logic [PORT_NUB*DATA_WIDTH-1:0]  rx_data,
  input  logic [PORT_NUB-1:0]             rx_last,
  output logic [PORT_NUB-1:0]             rx_ready,
  input  logic                            voq_full_in,
  output logic [WIDTH_SEL+DATA_WIDTH-1:0] data_out,
  output logic [WIDTH_SEL-1:0]            nub,
  output logic                            valid_out,
  output logic                            last_out,
  output logic                            frame_err
);
  localparam int CNT_W = $clog2(LENGTH_MAX + 1);

  typedef enum logic [1:0] {IDLE, HDR, XFER, DRAIN} state_t;

  state_t                state;
  logic                  full_q;
  logic [WIDTH_SEL-1:0]  ptr, grant, dest_q, arb_idx, hdr_dest, next_ptr;
  logic [WIDTH_SEL:0]    scan;
  logic                  arb_found;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] cur_word;
  logic                  cur_valid, cur_last, accept, dest_bad, at_max;

  // Rotating priority scan starting at ptr, wrapping modulo PORT_NUB.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    scan      = '0;
    for (int i = 0; i < PORT_NUB; i++) begin
      scan = {1'b0, ptr} + (WIDTH_SEL+1)'(i);
      if (scan >= (WIDTH_SEL+1)'(PORT_NUB))
        scan = scan - (WIDTH_SEL+1)'(PORT_NUB);
      if (!arb_found && rx_valid[scan[WIDTH_SEL-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = scan[WIDTH_SEL-1:0];
      end
    end
  end

  always_comb begin
    cur_word  = '0;
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    for (int i = 0; i < PORT_NUB; i++) begin
      if (grant == WIDTH_SEL'(i)) begin
        cur_word  = rx_data[i*DATA_WIDTH +: DATA_WIDTH];
        cur_valid = rx_valid[i];
        cur_last  = rx_last[i];
      end
    end
  end

  // DRAIN ignores backpressure: discarded beats never reach the VOQ.
  always_comb begin
    rx_ready = '0;
    if (state == DRAIN || ((state == HDR || state == XFER) && !full_q))
      rx_ready[grant] = 1'b1;
  end

  assign accept   = cur_valid && (|rx_ready);
  assign hdr_dest = cur_word[WIDTH_SEL-1:0];
  assign dest_bad = {1'b0, hdr_dest} >= (WIDTH_SEL+1)'(PORT_NUB);
  assign at_max   = (cnt == CNT_W'(LENGTH_MAX - 1));
  assign next_ptr = (arb_idx == WIDTH_SEL'(PORT_NUB - 1)) ? '0 : arb_idx + WIDTH_SEL'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      full_q    <= 1'b0;
      ptr       <= '0;
      grant     <= '0;
      dest_q    <= '0;
      cnt       <= '0;
      data_out  <= '0;
      nub       <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      full_q    <= voq_full_in;
      frame_err <= 1'b0;
      if (!full_q) begin
        valid_out <= 1'b0;
        last_out  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!full_q && arb_found) begin
            grant <= arb_idx;
            ptr   <= next_ptr;
            state <= HDR;
          end
        end
        HDR: begin
          if (accept) begin
            if (dest_bad) begin
              frame_err <= 1'b1;
              state     <= cur_last ? IDLE : DRAIN;
            end else begin
              dest_q    <= hdr_dest;
              data_out  <= {hdr_dest, cur_word};
              nub       <= grant;
              valid_out <= 1'b1;
              last_out  <= cur_last;
              cnt       <= CNT_W'(1);
              state     <= cur_last ? IDLE : XFER;
            end
          end
        end
        XFER: begin
          if (accept) begin
            data_out  <= {dest_q, cur_word};
            nub       <= grant;
            valid_out <= 1'b1;
            cnt       <= cnt + CNT_W'(1);
            if (cur_last) begin
              last_out <= 1'b1;
              state    <= IDLE;
            end else if (at_max) begin
              last_out  <= 1'b1;
              frame_err <= 1'b1;
              state     <= DRAIN;
            end else begin
              last_out <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (accept && cur_last)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_voq_rx_arbiter.sv
// tb/tb_voq_rx_arbiter.sv - directed self-checking bench for voq_rx_arbiter
module tb_voq_rx_arbiter;
  localparam int PN = 8;
  localparam int DW = 32;
  localparam int WS = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [PN-1:0]    src_valid = '0;
  logic [PN-1:0]    src_last = '0;
  logic [PN*DW-1:0] src_data = '0;
  logic             sel6 = 1'b0;
  logic             voq_full_in = 1'b0;
  logic             voq_full6 = 1'b0;

  logic [PN-1:0]    rx_valid8, rx_last8, rx_ready8;
  logic [WS+DW-1:0] data_out8;
  logic [WS-1:0]    nub8;
  logic             valid8, last8, ferr8;

  logic [5:0]       rx_valid6, rx_last6, rx_ready6;
  logic [6*DW-1:0]  rx_data6;
  logic [WS+DW-1:0] data_out6;
  logic [WS-1:0]    nub6;
  logic             valid6, last6, ferr6;

  assign rx_valid8 = sel6 ? '0 : src_valid;
  assign rx_last8  = sel6 ? '0 : src_last;
  assign rx_valid6 = sel6 ? src_valid[5:0] : '0;
  assign rx_last6  = sel6 ? src_last[5:0] : '0;
  assign rx_data6  = src_data[6*DW-1:0];

  voq_rx_arbiter #(.PORT_NUB(8), .DATA_WIDTH(32), .LENGTH_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid8), .rx_data(src_data), .rx_last(rx_last8),
    .rx_ready(rx_ready8), .voq_full_in(voq_full_in), .data_out(data_out8), .nub(nub8),
    .valid_out(valid8), .last_out(last8), .frame_err(ferr8)
  );

  voq_rx_arbiter #(.PORT_NUB(6), .DATA_WIDTH(32), .LENGTH_MAX(16)) dut6 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid6), .rx_data(rx_data6), .rx_last(rx_last6),
    .rx_ready(rx_ready6), .voq_full_in(voq_full6), .data_out(data_out6), .nub(nub6),
    .valid_out(valid6), .last_out(last6), .frame_err(ferr6)
  );

  logic [32:0] mem [PN][64];
  int          wr [PN];
  int          rd [PN];
  logic [PN-1:0] acc_n = '0;
  int          cyc = 0;
  logic        tb_fq;
  logic [63:0] obeat [256];
  int          ocyc [256];
  int          nout = 0, nerr = 0, nout6 = 0, nerr6 = 0;
  int          acc2_cyc = 0;
  bit          got2 = 1'b0;
  int          checks = 0, errors = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_fq <= 1'b0;
    else        tb_fq <= voq_full_in;

  // Source model: pops beats accepted at the last edge, then presents the next.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < PN; i++) begin
      if (acc_n[i] && rd[i] < wr[i]) rd[i]++;
      src_valid[i] = rd[i] < wr[i];
      src_data[i*DW +: DW] = mem[i][rd[i]][31:0];
      src_last[i] = mem[i][rd[i]][32] & src_valid[i];
    end
  end

  // Downstream model: a beat is taken in any cycle where the delayed full is low.
  always @(negedge clk) begin
    acc_n = src_valid & (sel6 ? {2'b00, rx_ready6} : rx_ready8);
    if (acc_n[2] && !got2) begin
      got2 = 1'b1;
      acc2_cyc = cyc;
    end
    if (valid8 && !tb_fq) begin
      obeat[nout] = {25'b0, last8, nub8, data_out8};
      ocyc[nout] = cyc;
      nout++;
    end
    if (ferr8) nerr++;
    if (valid6) nout6++;
    if (ferr6) nerr6++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word(input int p, input int j, input int d);
    return {4'hA, p[3:0], j[7:0], 13'h0, d[2:0]};
  endfunction

  function automatic logic [63:0] exp_beat(input int p, input int j, input int d, input bit last);
    return {25'b0, last, p[2:0], d[2:0], word(p, j, d)};
  endfunction

  task automatic push_frame(input int p, input int d, input int len);
    for (int j = 0; j < len; j++) begin
      mem[p][wr[p]] = {(j == len - 1), word(p, j, d)};
      wr[p]++;
    end
  endtask

  int base, e0, e6;
  int ord [3] = '{0, 3, 7};
  int dsts [3] = '{1, 4, 6};
  logic [63:0] snap;

  initial begin
    repeat (3) tick();
    chk("reset_valid", 64'(valid8), 64'd0);
    chk("reset_last", 64'(last8), 64'd0);
    chk("reset_data", 64'(data_out8), 64'd0);
    chk("reset_nub", 64'(nub8), 64'd0);
    chk("reset_ferr", 64'(ferr8), 64'd0);
    chk("reset_ready", 64'(rx_ready8), 64'd0);
    rst_n = 1'b1;
    tick();

    // Fairness: three ports hold 2-beat frames; grants rotate 0,3,7.
    base = nout;
    for (int k = 0; k < 3; k++) begin
      push_frame(0, 1, 2);
      push_frame(3, 4, 2);
      push_frame(7, 6, 2);
    end
    for (int n = 0; n < 300 && nout < base + 18; n++) tick();
    chk("fair_count", 64'(nout - base), 64'd18);
    for (int f = 0; f < 9; f++) begin
      chk("fair_hdr", obeat[base + 2*f], exp_beat(ord[f%3], 0, dsts[f%3], 1'b0));
      chk("fair_tail", obeat[base + 2*f + 1], exp_beat(ord[f%3], 1, dsts[f%3], 1'b1));
      if (f > 0) chk("fair_bubble", 64'(ocyc[base + 2*f] - ocyc[base + 2*f - 2]), 64'd3);
    end

    // Basic 4-beat frame from port 2 to destination 5.
    base = nout;
    push_frame(2, 5, 4);
    for (int n = 0; n < 100 && nout < base + 4; n++) tick();
    chk("basic_count", 64'(nout - base), 64'd4);
    for (int j = 0; j < 4; j++) chk("basic_beat", obeat[base + j], exp_beat(2, j, 5, j == 3));
    chk("basic_latency", 64'(ocyc[base] - acc2_cyc), 64'd1);

    // Backpressure: full held 3 cycles mid-frame.
    base = nout;
    push_frame(4, 3, 6);
    for (int n = 0; n < 100 && nout < base + 2; n++) tick();
    voq_full_in = 1'b1;
    tick();
    snap = {25'b0, last8, nub8, data_out8};
    chk("bp_ready_t1", 64'(rx_ready8), 64'd0);
    chk("bp_held_valid", 64'(valid8), 64'd1);
    tick();
    chk("bp_ready_t2", 64'(rx_ready8), 64'd0);
    chk("bp_hold_t2", {25'b0, last8, nub8, data_out8}, snap);
    chk("bp_valid_t2", 64'(valid8), 64'd1);
    tick();
    chk("bp_ready_t3", 64'(rx_ready8), 64'd0);
    chk("bp_hold_t3", {25'b0, last8, nub8, data_out8}, snap);
    voq_full_in = 1'b0;
    tick();
    chk("bp_hold_t4", {25'b0, last8, nub8, data_out8}, snap);
    chk("bp_ready_back", 64'(rx_ready8), 64'h10);
    for (int n = 0; n < 100 && nout < base + 6; n++) tick();
    repeat (4) tick();
    chk("bp_count", 64'(nout - base), 64'd6);
    for (int j = 0; j < 6; j++) chk("bp_beat", obeat[base + j], exp_beat(4, j, 3, j == 5));

    // Overlong: 20 beats, truncated at 16, remaining 4 drained under full.
    base = nout;
    e0 = nerr;
    push_frame(5, 2, 20);
    for (int n = 0; n < 200 && nout < base + 16; n++) tick();
    voq_full_in = 1'b1;
    tick();
    chk("drain_ready_full", 64'(rx_ready8), 64'h20);
    for (int n = 0; n < 50 && rd[5] < wr[5]; n++) tick();
    chk("drain_consumed", 64'(wr[5] - rd[5]), 64'd0);
    voq_full_in = 1'b0;
    repeat (4) tick();
    chk("long_count", 64'(nout - base), 64'd16);
    for (int j = 0; j < 16; j++) chk("long_beat", obeat[base + j], exp_beat(5, j, 2, j == 15));
    chk("long_ferr", 64'(nerr - e0), 64'd1);

    // Bad destination on the 6-port instance.
    sel6 = 1'b1;
    e6 = nerr6;
    push_frame(0, 7, 3);
    for (int n = 0; n < 50 && rd[0] < wr[0]; n++) tick();
    repeat (3) tick();
    chk("bad_no_valid", 64'(nout6), 64'd0);
    chk("bad_ferr", 64'(nerr6 - e6), 64'd1);
    push_frame(0, 2, 2);
    for (int n = 0; n < 50 && nout6 < 2; n++) tick();
    repeat (2) tick();
    chk("bad_recover_count", 64'(nout6), 64'd2);
    chk("bad_recover_data", 64'(data_out6), 64'({3'd2, word(0, 1, 2)}));
    sel6 = 1'b0;
    tick();

    // Reset mid-frame, then a clean frame from port 1.
    base = nout;
    push_frame(1, 3, 5);
    for (int n = 0; n < 100 && nout < base + 2; n++) tick();
    rst_n = 1'b0;
    for (int i = 0; i < PN; i++) wr[i] = rd[i];
    tick();
    chk("rst_valid", 64'(valid8), 64'd0);
    chk("rst_last", 64'(last8), 64'd0);
    chk("rst_data", 64'(data_out8), 64'd0);
    chk("rst_nub", 64'(nub8), 64'd0);
    chk("rst_ready", 64'(rx_ready8), 64'd0);
    chk("rst_abort_count", 64'(nout - base), 64'd2);
    rst_n = 1'b1;
    tick();
    base = nout;
    push_frame(1, 6, 3);
    for (int n = 0; n < 100 && nout < base + 3; n++) tick();
    repeat (2) tick();
    chk("rst_new_count", 64'(nout - base), 64'd3);
    for (int j = 0; j < 3; j++) chk("rst_new_beat", obeat[base + j], exp_beat(1, j, 6, j == 2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
